mem_arbiter2: RTL and testbench

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

---
 rtl/mem_arbiter2.sv | 138 +++++++++++++
 tb/tb_mem_arbiter2.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// Two-master memory arbiter with run-limited fairness and a single registered response stage.
// Request path is combinational with zero latency; responses arrive one cycle after mem_readdatavalid; downstream waitrequest stalls the granted master.
module mem_arbiter2 #(
    parameter int unsigned MAX_RUN = 4
) (
    input  logic        clock,
    input  logic        rst_n,

    input  logic [29:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_writedatamask,
    input  logic        m0_id,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    output logic        m0_readdataid,

    input  logic [29:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_writedatamask,
    input  logic        m1_id,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        m1_readdataid,

    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    output logic [1:0]  mem_id,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid,
    input  logic        mem_readdatavalid
);

    localparam logic [3:0] MAX_RUN_L = 4'(MAX_RUN);

    logic        last_q, last_d;
    logic [3:0]  run_q, run_d;
    logic        lock_q, lock_d;
    logic        lock_idx_q, lock_idx_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]  rsp_id_q, rsp_id_d;

    logic req0, req1;
    logic gnt_vld, gnt_idx;
    logic accept;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // A stalled transfer pins the grant; run==0 means no history, so the non-last master (m0 after reset) wins.
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = 1'b0;
        if (lock_q && (lock_idx_q ? req1 : req0)) begin
            gnt_idx = lock_idx_q;
        end else if (req0 && req1) begin
            gnt_idx = (run_q != 4'd0 && run_q < MAX_RUN_L) ? last_q : ~last_q;
        end else begin
            gnt_idx = req1;
        end
    end

    always_comb begin
        mem_address       = gnt_idx ? m1_address       : m0_address;
        mem_writedata     = gnt_idx ? m1_writedata     : m0_writedata;
        mem_writedatamask = gnt_idx ? m1_writedatamask : m0_writedatamask;
        mem_read          = gnt_vld & (gnt_idx ? m1_read  : m0_read);
        mem_write         = gnt_vld & (gnt_idx ? m1_write : m0_write);
        mem_id            = {gnt_idx, (gnt_idx ? m1_id : m0_id)};
        m0_waitrequest    = mem_waitrequest | ~(gnt_vld & ~gnt_idx);
        m1_waitrequest    = mem_waitrequest | ~(gnt_vld &  gnt_idx);
    end

    assign accept = gnt_vld & ~mem_waitrequest;

    always_comb begin
        last_d     = last_q;
        run_d      = run_q;
        lock_d     = gnt_vld & mem_waitrequest;
        lock_idx_d = gnt_idx;
        if (accept) begin
            if (gnt_idx == last_q) begin
                run_d = (run_q >= MAX_RUN_L) ? MAX_RUN_L : run_q + 4'd1;
            end else begin
                last_d = gnt_idx;
                run_d  = 4'd1;
            end
        end
    end

    always_comb begin
        rsp_vld_d = mem_readdatavalid;
        rsp_dat_d = rsp_dat_q;
        rsp_id_d  = rsp_id_q;
        if (mem_readdatavalid) begin
            rsp_dat_d = mem_readdata;
            rsp_id_d  = mem_readdataid;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            run_q      <= 4'd0;
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_dat_q  <= 32'd0;
            rsp_id_q   <= 2'd0;
        end else begin
            last_q     <= last_d;
            run_q      <= run_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign m0_readdata      = rsp_dat_q;
    assign m1_readdata      = rsp_dat_q;
    assign m0_readdatavalid = rsp_vld_q & ~rsp_id_q[1];
    assign m1_readdatavalid = rsp_vld_q &  rsp_id_q[1];
    assign m0_readdataid    = rsp_id_q[0];
    assign m1_readdataid    = rsp_id_q[0];

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2: expected grants and responses are queued at drive time and checked as the DUT produces them.
module tb_mem_arbiter2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_writedatamask = '0, m1_writedatamask = '0;
    logic        m0_id = 0, m1_id = 0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        m0_readdataid, m1_readdataid;
    logic [29:0] mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [1:0]  mem_id;
    logic        mem_waitrequest = 0;
    logic [31:0] mem_readdata = '0;
    logic [1:0]  mem_readdataid = '0;
    logic        mem_readdatavalid = 0;

    mem_arbiter2 #(.MAX_RUN(4)) dut (
        .clock(clock), .rst_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_writedatamask(m0_writedatamask), .m0_id(m0_id),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_readdataid(m0_readdataid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_writedatamask(m1_writedatamask), .m1_id(m1_id),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_readdataid(m1_readdataid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask), .mem_id(mem_id),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdataid(mem_readdataid), .mem_readdatavalid(mem_readdatavalid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        m;
        logic        id;
        logic [29:0] addr;
        logic        wr;
        logic [31:0] wdat;
        logic [3:0]  mask;
    } gnt_t;

    typedef struct {
        logic        m;
        logic        id;
        logic [31:0] dat;
        int          cyc;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    localparam logic [29:0] A0 = 30'h0000_1A0;
    localparam logic [29:0] A1 = 30'h0000_2B1;

    // Accepted transfers: one per edge where the presented request sees waitrequest low.
    always @(negedge clock) begin
        if (rst_n && (mem_read || mem_write) && !mem_waitrequest) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", 1, 0);
            end else begin
                gnt_t e;
                e = gq.pop_front();
                chk("gnt_master", mem_id[1], e.m);
                chk("gnt_id", mem_id[0], e.id);
                chk("gnt_addr", mem_address, e.addr);
                chk("gnt_write", mem_write, e.wr);
                if (e.wr) begin
                    chk("gnt_wdata", mem_writedata, e.wdat);
                    chk("gnt_mask", mem_writedatamask, e.mask);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (rst_n && (m0_readdatavalid || m1_readdatavalid)) begin
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                chk("rsp_valid_pair", {m1_readdatavalid, m0_readdatavalid}, e.m ? 2'b10 : 2'b01);
                chk("rsp_id", e.m ? m1_readdataid : m0_readdataid, e.id);
                chk("rsp_data", e.m ? m1_readdata : m0_readdata, e.dat);
                chk("rsp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_gnt(input logic m);
        gnt_t e;
        e.m = m;
        e.id = m ? m1_id : m0_id;
        e.addr = m ? A1 : A0;
        e.wr = 1'b0;
        e.wdat = '0;
        e.mask = '0;
        gq.push_back(e);
    endtask

    task automatic send_rsp(input logic [1:0] id, input logic [31:0] dat);
        rsp_t e;
        mem_readdatavalid = 1'b1;
        mem_readdataid = id;
        mem_readdata = dat;
        e.m = id[1];
        e.id = id[0];
        e.dat = dat;
        e.cyc = cyc + 1;
        rq.push_back(e);
    endtask

    initial begin
        m0_address = A0;
        m1_address = A1;
        m0_id = 1'b1;
        m1_id = 1'b0;

        // Reset state, and master 0 priority while still in reset.
        #12;
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_m1_rdv", m1_readdatavalid, 0);
        chk("rst_mem_read_idle", mem_read, 0);
        chk("rst_mem_write_idle", mem_write, 0);
        chk("rst_m0_wait_idle", m0_waitrequest, 1);
        m0_read = 1; m1_read = 1;
        #1;
        chk("rst_prio_m0", mem_id[1], 0);
        chk("rst_m1_wait", m1_waitrequest, 1);
        m0_read = 0; m1_read = 0;
        tick();
        rst_n = 1'b1;

        // Both read continuously: runs of four alternate, m0 first.
        tick();
        for (int i = 0; i < 12; i++) push_gnt(((i / 4) % 2) == 1);
        m0_read = 1; m1_read = 1;
        for (int i = 0; i < 12; i++) tick();
        m0_read = 0; m1_read = 0;

        // m1 alone streams 20 reads without bubbles, then the saturated run yields to m0.
        m1_read = 1;
        for (int i = 0; i < 20; i++) push_gnt(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("solo_m1_nowait", m1_waitrequest, 0);
            tick();
        end
        m0_read = 1;
        push_gnt(0); push_gnt(0); push_gnt(0); push_gnt(0); push_gnt(1);
        for (int i = 0; i < 5; i++) tick();
        m0_read = 0; m1_read = 0;

        // Stalled m0 write keeps the grant although m1 holds last with run below the limit.
        m0_write = 1; m0_writedata = 32'hCAFE_F00D; m0_writedatamask = 4'b0101;
        mem_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_gnt_m0", {mem_id[1], mem_write}, 2'b01);
            chk("stall_m0_wait", m0_waitrequest, 1);
            chk("stall_m1_wait", m1_waitrequest, 1);
            tick();
            m1_read = 1;
        end
        mem_waitrequest = 0;
        begin
            gnt_t e;
            e.m = 0; e.id = m0_id; e.addr = A0; e.wr = 1; e.wdat = 32'hCAFE_F00D; e.mask = 4'b0101;
            gq.push_back(e);
        end
        push_gnt(1);
        @(negedge clock);
        chk("accept_m1_still_wait", m1_waitrequest, 1);
        tick();
        m0_write = 0;
        @(negedge clock);
        chk("after_accept_m1_gnt", {mem_id[1], mem_read}, 2'b11);
        tick();
        m1_read = 0;

        // Single response to m1, then alternating back-to-back responses.
        send_rsp(2'b10, 32'hDEAD_BEEF);
        tick();
        send_rsp(2'b01, 32'h1111_0001);
        tick();
        send_rsp(2'b11, 32'h2222_0002);
        tick();
        send_rsp(2'b01, 32'h3333_0003);
        tick();
        send_rsp(2'b11, 32'h4444_0004);
        tick();
        mem_readdatavalid = 0;
        tick();

        // Build last=m1, run=3 with a response in flight, then reset mid-operation.
        m0_read = 1; push_gnt(0);
        tick();
        m0_read = 0; m1_read = 1;
        push_gnt(1); push_gnt(1); push_gnt(1);
        tick();
        tick();
        mem_readdatavalid = 1; mem_readdataid = 2'b10; mem_readdata = 32'h1234_5678;
        tick();
        m1_read = 0;
        mem_readdatavalid = 0;
        chk("pre_rst_m1_rdv", m1_readdatavalid, 1);
        rst_n = 0;
        #1;
        chk("rst_drop_m1_rdv", m1_readdatavalid, 0);
        chk("rst_drop_m0_rdv", m0_readdatavalid, 0);
        tick();
        rst_n = 1;
        tick();
        m0_read = 1; m1_read = 1;
        push_gnt(0);
        tick();
        m0_read = 0; m1_read = 0;
        tick();
        tick();

        chk("gnt_queue_drained", gq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
